// File: rtl/maxnet_pkg.sv
// Shared definitions for the maxnet host: FSM state encoding, default
// result width, FIFO entry width and small elaboration-time helpers.
package maxnet_pkg;

  localparam int RES_W_DEF   = 5;
  localparam int ENTRY_W_DEF = RES_W_DEF + 1;
  localparam int RUNS_W      = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_PUSH   = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  // Larger of two integers, used to size the shared hold/wait counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // A queued entry is the result plus one timeout flag bit on top.
  function automatic int entry_width(input int res_w);
    return res_w + 1;
  endfunction

endpackage

// File: rtl/maxnet_host_if.sv
// Bundle of the command, maxnet and result handshakes around maxnet_host.
// The master view is the host itself; the slave view is everything around it.
interface maxnet_host_if #(
  parameter int RES_W = maxnet_pkg::RES_W_DEF
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_runs;
  logic             mn_start;
  logic             mn_done;
  logic [RES_W-1:0] mn_result;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  logic             res_timeout;
  logic             cmd_done;
  logic             busy;
  logic [7:0]       to_count;

  modport master (
    input  cmd_valid, cmd_runs, mn_done, mn_result, res_ready,
    output cmd_ready, mn_start, res_valid, res_data, res_timeout,
           cmd_done, busy, to_count
  );

  modport slave (
    output cmd_valid, cmd_runs, mn_done, mn_result, res_ready,
    input  cmd_ready, mn_start, res_valid, res_data, res_timeout,
           cmd_done, busy, to_count
  );

endinterface

// File: rtl/maxnet_res_fifo.sv
// Small synchronous FIFO holding {timeout, result} entries. Pointers carry
// one extra wrap bit so full and empty are told apart without a counter.
// A push while full is taken when a pop happens in the same cycle.
module maxnet_res_fifo
  import maxnet_pkg::*;
#(
  parameter int WIDTH = ENTRY_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; reset flushes the queue by realigning both pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks the output.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/maxnet_host.sv
// Initiator for the maxnet start/done/result handshake. A command asks for
// a number of runs; each run pulses start, waits for done or a timeout, and
// queues {timeout, result} into the result FIFO. One counter is shared
// between the start-hold phase and the wait phase.
module maxnet_host
  import maxnet_pkg::*;
#(
  parameter int RES_W      = RES_W_DEF,
  parameter int START_HOLD = 3,
  parameter int TIMEOUT    = 300,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  maxnet_host_if.master bus
);

  localparam int CNT_MAX = max_int(START_HOLD, TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int ENTRY_W = entry_width(RES_W);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(START_HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RUNS_W-1:0]  runs_left_q, runs_left_d;
  logic [7:0]         to_count_q, to_count_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               tflag_q, tflag_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_dout;

  assign fifo_pop  = !fifo_empty && bus.res_ready;
  assign fifo_push = (state_q == S_PUSH) && (!fifo_full || fifo_pop);

  maxnet_res_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .din_i   ({tflag_q, result_q}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      runs_left_q <= '0;
      to_count_q  <= '0;
      result_q    <= '0;
      tflag_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      runs_left_q <= runs_left_d;
      to_count_q  <= to_count_d;
      result_q    <= result_d;
      tflag_q     <= tflag_d;
    end
  end

  // Next-state logic: sequence the runs of a command and catch done or timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    runs_left_d = runs_left_q;
    to_count_d  = to_count_q;
    result_d    = result_q;
    tflag_d     = tflag_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          runs_left_d = bus.cmd_runs;
          cnt_d       = '0;
          state_d     = (bus.cmd_runs == '0) ? S_FINISH : S_START;
        end
      end

      S_START: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT: begin
        if (bus.mn_done) begin
          result_d = bus.mn_result;
          tflag_d  = 1'b0;
          state_d  = S_PUSH;
        end else if (cnt_q == TIMEOUT_LAST) begin
          result_d = '0;
          tflag_d  = 1'b1;
          if (to_count_q != 8'hFF) to_count_d = to_count_q + 8'd1;
          state_d  = S_PUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_PUSH: begin
        if (fifo_push) begin
          runs_left_d = runs_left_q - 8'd1;
          cnt_d       = '0;
          state_d     = (runs_left_q == 8'd1) ? S_FINISH : S_START;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded straight from the registered state and the FIFO head.
  always_comb begin
    bus.cmd_ready   = (state_q == S_IDLE);
    bus.busy        = (state_q != S_IDLE);
    bus.mn_start    = (state_q == S_START);
    bus.cmd_done    = (state_q == S_FINISH);
    bus.to_count    = to_count_q;
    bus.res_valid   = !fifo_empty;
    bus.res_data    = fifo_dout[RES_W-1:0];
    bus.res_timeout = fifo_dout[RES_W];
  end

endmodule

// File: tb/tb_maxnet_host.sv
// Bench for maxnet_host: a behavioural maxnet answers each start burst with
// a programmable latency and result, a scoreboard holds the entries each
// queued run should produce, and a monitor checks them as they are popped.
module tb_maxnet_host;

  localparam int RES_W = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  maxnet_host_if #(.RES_W(RES_W)) ifc ();

  maxnet_host #(
    .RES_W      (RES_W),
    .START_HOLD (3),
    .TIMEOUT    (300),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  int nAssert = 0;
  int nFail   = 0;
  int cyc     = 0;

  logic [5:0]       expQ [$];
  int               latQ [$];
  logic [RES_W-1:0] resQ [$];

  int expCycles   = 0;
  int expToCount  = 0;
  int startHigh   = 0;
  int bursts      = 0;
  int doneCount   = 0;
  logic prevStart = 1'b0;
  logic [31:0] popExp;

  int               curLat = 0;
  int               mcnt   = 0;
  logic [RES_W-1:0] curRes = '0;
  logic             mStartPrev = 1'b0;
  logic             armed = 1'b0;

  // Free-running edge counter used to time-stamp events.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural maxnet: clears done on start, raises done with the queued
  // result a programmed number of cycles after start drops (0 = never).
  always @(posedge clk) begin
    if (rst) begin
      ifc.mn_done   <= 1'b0;
      ifc.mn_result <= '0;
      armed         <= 1'b0;
      mStartPrev    <= 1'b0;
      mcnt          <= 0;
    end else begin
      if (ifc.mn_start) begin
        if (!mStartPrev) begin
          curLat <= (latQ.size() != 0) ? latQ.pop_front() : 0;
          curRes <= (resQ.size() != 0) ? resQ.pop_front() : '0;
        end
        ifc.mn_done <= 1'b0;
        mcnt        <= 0;
        armed       <= 1'b1;
      end else if (armed) begin
        if (curLat != 0 && mcnt + 1 == curLat) begin
          ifc.mn_done   <= 1'b1;
          ifc.mn_result <= curRes;
          armed         <= 1'b0;
        end
        mcnt <= mcnt + 1;
      end
      mStartPrev <= ifc.mn_start;
    end
  end

  // Monitor: counts start activity and cmd_done pulses, and checks every
  // popped entry against the head of the scoreboard.
  always @(negedge clk) begin
    if (ifc.mn_start) startHigh++;
    if (ifc.mn_start && !prevStart) bursts++;
    prevStart = ifc.mn_start;
    if (ifc.cmd_done) doneCount++;
    if (!rst && ifc.res_valid && ifc.res_ready) begin
      popExp = (expQ.size() != 0) ? {26'd0, expQ.pop_front()} : 32'hDEAD;
      checkOutput("res_entry", {26'd0, ifc.res_timeout, ifc.res_data}, popExp);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Program one run into the maxnet model and the expected outcome into the scoreboard.
  task automatic queueRun(input int lat, input logic [RES_W-1:0] res);
    latQ.push_back(lat);
    resQ.push_back(res);
    if (lat == 0 || lat >= 300) begin
      expQ.push_back(6'b100000);
      expCycles += 304;
      expToCount = (expToCount < 255) ? expToCount + 1 : 255;
    end else begin
      expQ.push_back({1'b0, res});
      expCycles += lat + 5;
    end
  endtask

  task automatic applyStimulus(input int runs, output int acceptCyc);
    checkOutput("cmd_ready_before_cmd", ifc.cmd_ready, 1);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_runs  = 8'(runs);
    tick();
    acceptCyc     = cyc;
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic waitCmdDone(input int budget, input int expCyc, input string tag);
    int got = 0;
    int seenCyc = -1;
    for (int i = 0; i < budget && got == 0; i++) begin
      @(negedge clk);
      if (ifc.cmd_done) begin
        got = 1;
        seenCyc = cyc;
      end
    end
    checkOutput({tag, "_done_seen"}, got, 1);
    if (got != 0) checkOutput({tag, "_done_cycle"}, seenCyc, expCyc);
    tick();
  endtask

  task automatic drain(input int budget, input string tag);
    for (int i = 0; i < budget && expQ.size() != 0; i++) tick();
    checkOutput({tag, "_sb_drained"}, expQ.size(), 0);
  endtask

  int acc, b0, h0, d0, r0;

  initial begin
    rst           = 1'b1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_runs  = 8'd0;
    ifc.res_ready = 1'b0;
    tick(3);

    $display("[TB] reset state");
    checkOutput("rst_cmd_ready", ifc.cmd_ready, 1);
    checkOutput("rst_busy", ifc.busy, 0);
    checkOutput("rst_res_valid", ifc.res_valid, 0);
    checkOutput("rst_mn_start", ifc.mn_start, 0);
    checkOutput("rst_cmd_done", ifc.cmd_done, 0);
    checkOutput("rst_to_count", ifc.to_count, 0);
    checkOutput("rst_res_data", ifc.res_data, 0);
    checkOutput("rst_res_timeout", ifc.res_timeout, 0);
    rst = 1'b0;
    tick();

    $display("[TB] zero-run command");
    b0 = bursts;
    applyStimulus(0, acc);
    waitCmdDone(10, acc, "zero");
    checkOutput("zero_no_start", bursts - b0, 0);
    checkOutput("zero_no_entry", ifc.res_valid, 0);
    checkOutput("zero_idle", ifc.busy, 0);

    $display("[TB] single run, latency 20");
    ifc.res_ready = 1'b1;
    expCycles = 0;
    b0 = bursts; h0 = startHigh; d0 = doneCount;
    queueRun(20, 5'd17);
    applyStimulus(1, acc);
    waitCmdDone(100, acc + expCycles, "t1");
    drain(20, "t1");
    checkOutput("t1_start_cycles", startHigh - h0, 3);
    checkOutput("t1_start_bursts", bursts - b0, 1);
    checkOutput("t1_one_done", doneCount - d0, 1);
    checkOutput("t1_to_count", ifc.to_count, expToCount);

    $display("[TB] three runs");
    expCycles = 0;
    b0 = bursts; d0 = doneCount;
    queueRun(10, 5'd3);
    queueRun(4, 5'd9);
    queueRun(7, 5'd30);
    applyStimulus(3, acc);
    waitCmdDone(200, acc + expCycles, "t2");
    drain(20, "t2");
    checkOutput("t2_start_bursts", bursts - b0, 3);
    checkOutput("t2_one_done", doneCount - d0, 1);

    $display("[TB] two timeouts");
    expCycles = 0;
    b0 = bursts;
    queueRun(0, 5'd0);
    queueRun(0, 5'd0);
    applyStimulus(2, acc);
    waitCmdDone(700, acc + expCycles, "t3");
    drain(20, "t3");
    checkOutput("t3_to_count", ifc.to_count, expToCount);
    checkOutput("t3_start_bursts", bursts - b0, 2);

    $display("[TB] FIFO backpressure");
    ifc.res_ready = 1'b0;
    b0 = bursts; d0 = doneCount;
    for (int i = 0; i < 6; i++) queueRun(5, 5'(11 + i));
    applyStimulus(6, acc);
    tick(80);
    checkOutput("t4_res_valid", ifc.res_valid, 1);
    checkOutput("t4_head", {ifc.res_timeout, ifc.res_data}, expQ[0]);
    checkOutput("t4_bursts_at_stall", bursts - b0, 5);
    h0 = startHigh;
    tick(40);
    checkOutput("t4_stall_no_start", startHigh - h0, 0);
    checkOutput("t4_stall_busy", ifc.busy, 1);
    checkOutput("t4_no_done_yet", doneCount - d0, 0);
    ifc.res_ready = 1'b1;
    r0 = cyc;
    waitCmdDone(100, r0 + 11, "t4");
    drain(20, "t4");
    checkOutput("t4_bursts_total", bursts - b0, 6);

    $display("[TB] done at last wait cycle");
    expCycles = 0;
    queueRun(299, 5'd21);
    applyStimulus(1, acc);
    waitCmdDone(400, acc + expCycles, "t5");
    drain(20, "t5");
    checkOutput("t5_to_count", ifc.to_count, expToCount);

    $display("[TB] reset during wait");
    ifc.res_ready = 1'b0;
    queueRun(5, 5'd7);
    queueRun(5, 5'd8);
    queueRun(0, 5'd0);
    applyStimulus(3, acc);
    tick(40);
    checkOutput("t6_entries_queued", ifc.res_valid, 1);
    checkOutput("t6_busy_before", ifc.busy, 1);
    rst = 1'b1;
    expQ.delete();
    latQ.delete();
    resQ.delete();
    expToCount = 0;
    tick();
    checkOutput("t6_busy", ifc.busy, 0);
    checkOutput("t6_res_valid", ifc.res_valid, 0);
    checkOutput("t6_mn_start", ifc.mn_start, 0);
    checkOutput("t6_cmd_ready", ifc.cmd_ready, 1);
    checkOutput("t6_to_count", ifc.to_count, 0);
    rst = 1'b0;
    tick(2);

    $display("[TB] recovery after reset");
    ifc.res_ready = 1'b1;
    expCycles = 0;
    queueRun(3, 5'd19);
    applyStimulus(1, acc);
    waitCmdDone(50, acc + expCycles, "t7");
    drain(20, "t7");

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
